// File: rtl/pipe_register.sv
// pipe_register: elastic chain of DEPTH N-bit stages with valid/ready handshake on both
// sides and synchronous flush; define PIPE_REG_COUNT_EN to add the occupancy port count.
module pipe_register #(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N-1:0]                 in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N-1:0]                 out_data
`ifdef PIPE_REG_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   count
`endif
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [N-1:0]     dat [DEPTH];
  logic [N-1:0]     nxt [DEPTH];
  logic             acc;

  // A stage advances when its successor is empty or is itself advancing, so the
  // ready chain ripples back from the output and bubbles are squeezed out.
  always_comb begin
    logic go;
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    adv          = '0;
    go           = vld[DEPTH-1] & out_ready & ~flush;
    adv[DEPTH-1] = go;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      go     = vld[k] & (~vld[k+1] | go);
      adv[k] = go;
    end
  end

  assign in_ready  = ~flush & (~vld[0] | adv[0]);
  assign acc       = in_valid & in_ready;
  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

  // Flush suppresses internal moves too, so the output word is frozen once invalidated.
  always_comb begin
    load    = '0;
    load[0] = acc;
    nxt[0]  = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      load[k] = adv[k-1] & ~flush;
      nxt[k]  = dat[k-1];
    end
  end

  // NOTE: the data registers are reset as well, because out_data must read 0 after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      for (int k = 0; k < DEPTH; k++) dat[k] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all stages shift in lockstep.
      for (int k = 0; k < DEPTH; k++) begin
        if (flush)        vld[k] <= 1'b0;
        else if (load[k]) vld[k] <= 1'b1;
        else if (adv[k])  vld[k] <= 1'b0;
        if (load[k]) dat[k] <= nxt[k];
      end
    end
  end

`ifdef PIPE_REG_COUNT_EN
  localparam int CW = $clog2(DEPTH + 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     count <= '0;
    else if (flush) count <= '0;
    else            count <= count + CW'(acc) - CW'(adv[DEPTH-1]);
  end
`endif

endmodule
